// File: rtl/farm_sensor_conditioner_if.sv
// Signal bundle between the farm-road loop detector front end and the
// highway/farm traffic light controller.
//   sensor_raw   : raw loop detector level, asynchronous to clk
//   farm_green   : controller is showing farm green
//   req_c        : latched vehicle request to controller input C
//   sensor_clean : synchronised, debounced detector level
//   veh_count    : qualified arrivals since last service (saturating)
//   fault        : detector stuck-on
// master drives the detector/controller side; slave is the conditioner.
interface farm_sensor_conditioner_if;
  logic       sensor_raw;
  logic       farm_green;
  logic       req_c;
  logic       sensor_clean;
  logic [7:0] veh_count;
  logic       fault;

  modport master (
    output sensor_raw, farm_green,
    input  req_c, sensor_clean, veh_count, fault
  );

  modport slave (
    input  sensor_raw, farm_green,
    output req_c, sensor_clean, veh_count, fault
  );
endinterface

// File: rtl/farm_sensor_conditioner.sv
// Conditions the raw farm-road loop detector into the clean request C for
// the traffic light controller: 2-flop sync, ms-tick debounce, minimum
// presence qualification, request latch until served, arrival counting and
// stuck-on detection.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of farm_sensor_conditioner_if (see interface header)
module farm_sensor_conditioner #(
  parameter int unsigned TICK_DIV        = 50_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned MIN_PRESENCE_MS = 200,
  parameter int unsigned STUCK_MS        = 60_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  farm_sensor_conditioner_if.slave    bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);

  typedef enum logic [2:0] {
    IDLE,
    DETECT,
    REQUEST,
    SERVING,
    FAULT
  } state_e;

  logic          meta_q, sync_q;
  logic [PW-1:0] presc_q;
  logic [DW-1:0] db_cnt_q;
  logic          clean_q, clean_prev_q;
  logic          tick, clean_rise;
  state_e        state_q;
  logic [15:0]   pres_q;
  logic [7:0]    veh_q, veh_inc;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign clean_rise = clean_q & ~clean_prev_q;

  always_comb begin
    veh_inc = veh_q;
    if (veh_q != 8'hFF) veh_inc = veh_q + 8'd1;
  end

  // Front end: synchroniser, ms prescaler and debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      presc_q      <= '0;
      db_cnt_q     <= '0;
      clean_q      <= 1'b0;
      clean_prev_q <= 1'b0;
    end else begin
      meta_q       <= bus.sensor_raw;
      sync_q       <= meta_q;
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      clean_prev_q <= clean_q;
      if (tick) begin
        if (sync_q != clean_q) begin
          // Flip on the DEBOUNCE_MS-th consecutive mismatching tick.
          if (db_cnt_q == DW'(DEBOUNCE_MS - 1)) begin
            clean_q  <= sync_q;
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
    end
  end

  // Request FSM with presence timer and arrival counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pres_q  <= '0;
      veh_q   <= '0;
    end else begin
      if (!clean_q)
        pres_q <= '0;
      else if (tick && (state_q == DETECT || state_q == REQUEST) && pres_q != '1)
        pres_q <= pres_q + 16'd1;

      unique case (state_q)
        IDLE: begin
          if (clean_rise) begin
            state_q <= DETECT;
            pres_q  <= '0;
          end
        end
        DETECT: begin
          if (!clean_q) begin
            state_q <= IDLE;
          end else if (bus.farm_green) begin
            state_q <= SERVING;
            veh_q   <= '0;
          end else if (tick && pres_q == 16'(MIN_PRESENCE_MS - 1)) begin
            state_q <= REQUEST;
            veh_q   <= veh_inc;
          end
        end
        REQUEST: begin
          if (bus.farm_green) begin
            state_q <= SERVING;
            veh_q   <= '0;
          end else if (tick && clean_q && pres_q == 16'(STUCK_MS - 1)) begin
            // Clear on the way to FAULT beats a same-cycle arrival.
            state_q <= FAULT;
            veh_q   <= '0;
          end else if (clean_rise) begin
            veh_q <= veh_inc;
          end
        end
        SERVING: begin
          if (!bus.farm_green) begin
            if (clean_q) begin
              state_q <= DETECT;
              pres_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FAULT: begin
          veh_q <= '0;
          if (!clean_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_c        = (state_q == REQUEST);
  assign bus.fault        = (state_q == FAULT);
  assign bus.sensor_clean = clean_q;
  assign bus.veh_count    = veh_q;

endmodule

// File: tb/tb_farm_sensor_conditioner.sv
module tb_farm_sensor_conditioner;

  logic clk;
  logic rst_n;

  farm_sensor_conditioner_if bus ();

  farm_sensor_conditioner #(
    .TICK_DIV       (4),
    .DEBOUNCE_MS    (3),
    .MIN_PRESENCE_MS(5),
    .STUCK_MS       (50)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sel: 0 sensor_clean, 1 req_c, 2 fault
  function automatic logic pick(input int sel);
    case (sel)
      0:       return bus.sensor_clean;
      1:       return bus.req_c;
      default: return bus.fault;
    endcase
  endfunction

  // Called at a negedge; waits at most budget negedges for the output to reach lvl.
  task automatic wait_out(input int sel, input logic lvl, input int budget, input string tag);
    int n = 0;
    while (pick(sel) !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(pick(sel)), 32'(lvl));
  endtask

  task automatic pulse();
    bus.sensor_raw = 1'b1;
    wait_out(0, 1'b1, 20, "pulse_hi");
    bus.sensor_raw = 1'b0;
    wait_out(0, 1'b0, 20, "pulse_lo");
  endtask

  initial begin
    bit seen;
    rst_n          = 1'b0;
    bus.sensor_raw = 1'b0;
    bus.farm_green = 1'b0;

    // Reset held while the detector chatters.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.sensor_raw = ~bus.sensor_raw;
    end
    check_eq("rst_req",   32'(bus.req_c), 0);
    check_eq("rst_clean", 32'(bus.sensor_clean), 0);
    check_eq("rst_fault", 32'(bus.fault), 0);
    check_eq("rst_veh",   32'(bus.veh_count), 0);
    @(negedge clk);
    bus.sensor_raw = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("idle_clean", 32'(bus.sensor_clean), 0);
    check_eq("idle_req",   32'(bus.req_c), 0);

    // Two 2-tick glitches separated by a quiet tick: never seen downstream.
    seen = 1'b0;
    bus.sensor_raw = 1'b1;
    repeat (8) begin @(negedge clk); seen |= bus.sensor_clean | bus.req_c; end
    bus.sensor_raw = 1'b0;
    repeat (6) begin @(negedge clk); seen |= bus.sensor_clean | bus.req_c; end
    bus.sensor_raw = 1'b1;
    repeat (8) begin @(negedge clk); seen |= bus.sensor_clean | bus.req_c; end
    bus.sensor_raw = 1'b0;
    repeat (30) begin @(negedge clk); seen |= bus.sensor_clean | bus.req_c; end
    check_eq("glitch_hidden", 32'(seen), 0);

    // Steady vehicle: debounce window, qualify window, latch, service.
    bus.sensor_raw = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("db_early", 32'(bus.sensor_clean), 0);
    wait_out(0, 1'b1, 4, "db_rise");
    repeat (17) @(negedge clk);
    check_eq("req_early", 32'(bus.req_c), 0);
    wait_out(1, 1'b1, 4, "req_rise");
    check_eq("veh_one", 32'(bus.veh_count), 1);
    bus.sensor_raw = 1'b0;
    wait_out(0, 1'b0, 20, "clean_fall");
    repeat (3) @(negedge clk);
    check_eq("req_latched", 32'(bus.req_c), 1);
    check_eq("veh_held",    32'(bus.veh_count), 1);
    bus.farm_green = 1'b1;
    @(negedge clk);
    check_eq("req_served", 32'(bus.req_c), 0);
    check_eq("veh_served", 32'(bus.veh_count), 0);
    repeat (3) @(negedge clk);
    bus.farm_green = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("post_serve_req",   32'(bus.req_c), 0);
    check_eq("post_serve_fault", 32'(bus.fault), 0);

    // Green while idle does nothing.
    bus.farm_green = 1'b1;
    repeat (5) @(negedge clk);
    bus.farm_green = 1'b0;
    check_eq("idle_green_req", 32'(bus.req_c), 0);

    // Short presence (about 3 ticks) is a transient.
    bus.sensor_raw = 1'b1;
    wait_out(0, 1'b1, 20, "short_rise");
    bus.sensor_raw = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen |= bus.req_c; end
    check_eq("short_no_req", 32'(seen), 0);
    check_eq("short_veh",    32'(bus.veh_count), 0);

    // Arrivals while requesting, then saturation.
    bus.sensor_raw = 1'b1;
    wait_out(1, 1'b1, 60, "cnt_req");
    bus.sensor_raw = 1'b0;
    wait_out(0, 1'b0, 20, "cnt_clean_fall");
    for (int i = 0; i < 3; i++) pulse();
    check_eq("veh_four", 32'(bus.veh_count), 4);
    for (int i = 0; i < 297; i++) pulse();
    check_eq("veh_sat",   32'(bus.veh_count), 255);
    check_eq("sat_req",   32'(bus.req_c), 1);
    check_eq("sat_fault", 32'(bus.fault), 0);
    bus.farm_green = 1'b1;
    @(negedge clk);
    check_eq("sat_served_veh", 32'(bus.veh_count), 0);
    bus.farm_green = 1'b0;
    repeat (3) @(negedge clk);

    // Stuck-on detector: fault exactly 45 ticks after the request.
    bus.sensor_raw = 1'b1;
    wait_out(1, 1'b1, 60, "stuck_req");
    repeat (179) @(negedge clk);
    check_eq("fault_early", 32'(bus.fault), 0);
    check_eq("req_before_fault", 32'(bus.req_c), 1);
    @(negedge clk);
    check_eq("fault_set",  32'(bus.fault), 1);
    check_eq("fault_req",  32'(bus.req_c), 0);
    check_eq("fault_veh",  32'(bus.veh_count), 0);
    bus.sensor_raw = 1'b0;
    wait_out(0, 1'b0, 20, "fault_release");
    @(negedge clk);
    check_eq("fault_clear", 32'(bus.fault), 0);
    bus.sensor_raw = 1'b1;
    wait_out(1, 1'b1, 60, "rereq");
    check_eq("rereq_veh", 32'(bus.veh_count), 1);
    bus.sensor_raw = 1'b0;
    wait_out(0, 1'b0, 20, "rereq_release");
    bus.farm_green = 1'b1;
    @(negedge clk);
    bus.farm_green = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a request.
    bus.sensor_raw = 1'b1;
    wait_out(1, 1'b1, 60, "rst_mid_req");
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_req",   32'(bus.req_c), 0);
    check_eq("async_veh",   32'(bus.veh_count), 0);
    check_eq("async_clean", 32'(bus.sensor_clean), 0);
    bus.sensor_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("after_rst_req", 32'(bus.req_c), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
